// File: rtl/window_gen_3x3_pkg.sv
// Shared definitions for the 3x3 window generator: default widths,
// the FSM state type and the window slot numbering helper.
package window_gen_3x3_pkg;

  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_F          = 3;

  typedef enum logic {
    IDLE,
    ACTIVE
  } state_e;

  // Slot number of window element (wr, wc); wr=0 is the oldest row,
  // wc=0 the leftmost column, so the newest pixel lands in the last slot.
  function automatic int win_idx(input int wr, input int wc);
    return wr * DEF_F + wc;
  endfunction

endpackage

// File: rtl/window_gen_3x3_line_buffer.sv
// One-row delay line: returns the pixel written IMG_W accepted pixels ago
// at the same column, then overwrites that entry with the incoming pixel.
module window_gen_3x3_line_buffer
  import window_gen_3x3_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int IMG_W      = 28,
  parameter int AW         = 5
) (
  input  logic                  clk,
  input  logic                  in_valid,
  input  logic [AW-1:0]         col_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic [DATA_WIDTH-1:0] data_o
);

  logic [DATA_WIDTH-1:0] mem_q [IMG_W];

  assign data_o = mem_q[col_i];

  // Storage is left unreset: every entry is rewritten before a window uses it.
  always_ff @(posedge clk) begin
    if (in_valid) begin
      mem_q[col_i] <= data_i;
    end
  end

endmodule

// File: rtl/window_gen_3x3.sv
// Turns a raster-order pixel stream into 3x3 sliding windows, emitting only
// windows that lie fully inside the image, with frame start/end tracking.
module window_gen_3x3
  import window_gen_3x3_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int F          = DEF_F,
  parameter int IMG_W      = 28,
  parameter int IMG_H      = 28
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  input  logic                      in_sof,
  input  logic [DATA_WIDTH-1:0]     pixel_in,
  output logic [DATA_WIDTH*F*F-1:0] oData,
  output logic                      window_valid,
  output logic                      frame_done
);

  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [CW-1:0] LAST_COL = CW'(IMG_W - 1);
  localparam logic [RW-1:0] LAST_ROW = RW'(IMG_H - 1);
  localparam logic [CW-1:0] MIN_COL  = CW'(F - 1);
  localparam logic [RW-1:0] MIN_ROW  = RW'(F - 1);

  state_e                    state_q;
  logic [CW-1:0]             col_q, col_d, curCol;
  logic [RW-1:0]             row_q, row_d, curRow;
  logic                      lastPix, emitWin;
  logic [DATA_WIDTH-1:0]     rowAbove1, rowAbove2;
  logic [DATA_WIDTH-1:0]     colNew  [F];
  logic [DATA_WIDTH-1:0]     win_q   [F][F];
  logic [DATA_WIDTH-1:0]     winNext [F][F];
  logic [DATA_WIDTH*F*F-1:0] packedNext;
  logic [DATA_WIDTH*F*F-1:0] oData_q;
  logic                      window_valid_q, frame_done_q;

  // Position of the pixel on the input this cycle; a start-of-frame or an
  // idle FSM forces (0,0) so an abandoned frame leaves no trace in the counters.
  always_comb begin
    curCol = col_q;
    curRow = row_q;
    if (in_sof || state_q == IDLE) begin
      curCol = '0;
      curRow = '0;
    end
    lastPix = (curCol == LAST_COL) && (curRow == LAST_ROW);
    emitWin = in_valid && (curCol >= MIN_COL) && (curRow >= MIN_ROW);
  end

  // Raster counter advance: column wraps into the next row, last pixel wraps to (0,0).
  always_comb begin
    col_d = curCol + CW'(1);
    row_d = curRow;
    if (curCol == LAST_COL) begin
      col_d = '0;
      row_d = lastPix ? '0 : curRow + RW'(1);
    end
  end

  window_gen_3x3_line_buffer #(
    .DATA_WIDTH (DATA_WIDTH),
    .IMG_W      (IMG_W),
    .AW         (CW)
  ) u_lineBuf0 (
    .clk      (clk),
    .in_valid (in_valid),
    .col_i    (curCol),
    .data_i   (pixel_in),
    .data_o   (rowAbove1)
  );

  window_gen_3x3_line_buffer #(
    .DATA_WIDTH (DATA_WIDTH),
    .IMG_W      (IMG_W),
    .AW         (CW)
  ) u_lineBuf1 (
    .clk      (clk),
    .in_valid (in_valid),
    .col_i    (curCol),
    .data_i   (rowAbove1),
    .data_o   (rowAbove2)
  );

  // Next window: drop the left column, append the incoming column (oldest row on top).
  always_comb begin
    colNew[0] = rowAbove2;
    colNew[1] = rowAbove1;
    colNew[2] = pixel_in;
    packedNext = '0;
    for (int wr = 0; wr < F; wr++) begin
      winNext[wr][0] = win_q[wr][1];
      winNext[wr][1] = win_q[wr][2];
      winNext[wr][2] = colNew[wr];
      for (int wc = 0; wc < F; wc++) begin
        packedNext[win_idx(wr, wc)*DATA_WIDTH +: DATA_WIDTH] = winNext[wr][wc];
      end
    end
  end

  // Window registers shift on every accepted pixel, including across row wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_q <= '{default: '0};
    end else if (in_valid) begin
      win_q <= winNext;
    end
  end

  // Frame FSM, raster counters and registered outputs; oData holds between windows.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      col_q          <= '0;
      row_q          <= '0;
      oData_q        <= '0;
      window_valid_q <= 1'b0;
      frame_done_q   <= 1'b0;
    end else begin
      window_valid_q <= 1'b0;
      frame_done_q   <= 1'b0;
      if (in_valid) begin
        col_q <= col_d;
        row_q <= row_d;
        case (state_q)
          IDLE:    state_q <= lastPix ? IDLE : ACTIVE;
          ACTIVE:  state_q <= lastPix ? IDLE : ACTIVE;
          default: state_q <= IDLE;
        endcase
        if (emitWin) begin
          oData_q        <= packedNext;
          window_valid_q <= 1'b1;
          frame_done_q   <= lastPix;
        end
      end
    end
  end

  assign oData        = oData_q;
  assign window_valid = window_valid_q;
  assign frame_done   = frame_done_q;

endmodule

// File: tb/tb_window_gen_3x3.sv
// Bench for window_gen_3x3 on a 5x4 image: an image-array model predicts
// every output cycle, and literal windows pin the model to known values.
module tb_window_gen_3x3;

  localparam int DW    = 16;
  localparam int F     = 3;
  localparam int IMG_W = 5;
  localparam int IMG_H = 4;
  localparam int NW    = DW * F * F;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_sof;
  logic [DW-1:0] pixel_in;
  logic [NW-1:0] oData;
  logic          window_valid;
  logic          frame_done;

  int            errors = 0;
  int            checks = 0;

  int            mImg [IMG_H][IMG_W];
  int            mRow, mCol;
  bit            mActive;
  logic [NW-1:0] expData;
  logic          expValid, expDone;

  logic [NW-1:0] obsData [$];
  int            doneSeen;
  logic          lastWv;
  logic [NW-1:0] lastData;
  int            lst [9];

  window_gen_3x3 #(
    .DATA_WIDTH (DW),
    .F          (F),
    .IMG_W      (IMG_W),
    .IMG_H      (IMG_H)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_sof       (in_sof),
    .pixel_in     (pixel_in),
    .oData        (oData),
    .window_valid (window_valid),
    .frame_done   (frame_done)
  );

  // Free-running clock, period 10
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [NW-1:0] act, input logic [NW-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  function automatic logic [NW-1:0] packList(input int p [9]);
    logic [NW-1:0] v;
    v = '0;
    for (int i = 0; i < 9; i++) v[i*DW +: DW] = p[i][DW-1:0];
    return v;
  endfunction

  task automatic modelReset();
    mRow     = 0;
    mCol     = 0;
    mActive  = 1'b0;
    expData  = '0;
    expValid = 1'b0;
    expDone  = 1'b0;
  endtask

  // Image-level model: place the pixel, and if a full 3x3 fits ending here,
  // the window is the image rectangle above-left of it.
  task automatic modelStep(input logic valid, input logic sof, input int pix);
    int r, c;
    expValid = 1'b0;
    expDone  = 1'b0;
    if (valid) begin
      if (sof || !mActive) begin
        r = 0;
        c = 0;
      end else begin
        r = mRow;
        c = mCol;
      end
      mImg[r][c] = pix;
      if (r >= 2 && c >= 2) begin
        expValid = 1'b1;
        for (int wr = 0; wr < 3; wr++)
          for (int wc = 0; wc < 3; wc++)
            expData[(wr*3+wc)*DW +: DW] = mImg[r-2+wr][c-2+wc][DW-1:0];
        expDone = (r == IMG_H-1) && (c == IMG_W-1);
      end
      if (c == IMG_W-1) begin
        mCol = 0;
        if (r == IMG_H-1) begin
          mRow    = 0;
          mActive = 1'b0;
        end else begin
          mRow    = r + 1;
          mActive = 1'b1;
        end
      end else begin
        mCol    = c + 1;
        mRow    = r;
        mActive = 1'b1;
      end
    end
  endtask

  task automatic compareNow();
    checkOutput("oData", oData, expData);
    checkOutput("window_valid", {{(NW-1){1'b0}}, window_valid}, {{(NW-1){1'b0}}, expValid});
    checkOutput("frame_done", {{(NW-1){1'b0}}, frame_done}, {{(NW-1){1'b0}}, expDone});
    lastWv   = window_valid;
    lastData = oData;
    if (window_valid === 1'b1) obsData.push_back(oData);
    if (frame_done === 1'b1) doneSeen++;
  endtask

  // One cycle: check what the previous cycle produced, then drive this cycle
  task automatic applyStimulus(input logic valid, input logic sof, input int pix);
    @(negedge clk);
    compareNow();
    in_valid = valid;
    in_sof   = sof;
    pixel_in = pix[DW-1:0];
    modelStep(valid, sof, pix);
  endtask

  task automatic clearObs();
    obsData.delete();
    doneSeen = 0;
  endtask

  task automatic checkObs(input string name, input int k);
    if (k < obsData.size()) begin
      checkOutput(name, obsData[k], packList(lst));
    end else begin
      checks++;
      errors++;
      $display("[TB] FAIL %s: got no window %0d, required one", name, k);
    end
  endtask

  task automatic sendFrame(input int base, input logic sof, input bit gaps);
    for (int i = 0; i < IMG_W*IMG_H; i++) begin
      applyStimulus(1'b1, sof && (i == 0), base + i);
      if (gaps && ((i % 3) == 1)) begin
        repeat ($urandom_range(1, 2)) applyStimulus(1'b0, 1'b0, 16'hDEAD);
      end
    end
  endtask

  initial begin
    rst_n    = 1'b1;
    in_valid = 1'b0;
    in_sof   = 1'b0;
    pixel_in = '0;
    doneSeen = 0;
    modelReset();
    #1 rst_n = 1'b0;
    @(negedge clk);
    checkOutput("reset_oData", oData, '0);
    checkOutput("reset_window_valid", {{(NW-1){1'b0}}, window_valid}, '0);
    checkOutput("reset_frame_done", {{(NW-1){1'b0}}, frame_done}, '0);
    rst_n = 1'b1;

    $display("[TB] continuous frame with row-wrap checks");
    clearObs();
    for (int i = 0; i < 16; i++) applyStimulus(1'b1, i == 0, i);
    applyStimulus(1'b1, 1'b0, 16);
    checkOutput("wrap_after_15", {{(NW-1){1'b0}}, lastWv}, '0);
    applyStimulus(1'b1, 1'b0, 17);
    checkOutput("wrap_after_16", {{(NW-1){1'b0}}, lastWv}, '0);
    applyStimulus(1'b1, 1'b0, 18);
    checkOutput("wrap_after_17", {{(NW-1){1'b0}}, lastWv}, {{(NW-1){1'b0}}, 1'b1});
    lst = '{5, 6, 7, 10, 11, 12, 15, 16, 17};
    checkOutput("wrap_window_17", lastData, packList(lst));
    applyStimulus(1'b1, 1'b0, 19);
    applyStimulus(1'b0, 1'b0, 0);
    checkOutput("cont_count", NW'(obsData.size()), NW'(6));
    checkOutput("cont_done", NW'(doneSeen), NW'(1));
    lst = '{0, 1, 2, 5, 6, 7, 10, 11, 12};
    checkObs("cont_first", 0);
    lst = '{7, 8, 9, 12, 13, 14, 17, 18, 19};
    checkObs("cont_last", 5);

    $display("[TB] frame with input gaps");
    clearObs();
    sendFrame(0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 0);
    checkOutput("gap_count", NW'(obsData.size()), NW'(6));
    lst = '{0, 1, 2, 5, 6, 7, 10, 11, 12};
    checkObs("gap_first", 0);
    lst = '{2, 3, 4, 7, 8, 9, 12, 13, 14};
    checkObs("gap_third", 2);
    lst = '{7, 8, 9, 12, 13, 14, 17, 18, 19};
    checkObs("gap_last", 5);

    $display("[TB] start-of-frame restart at pixel 8");
    clearObs();
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, i == 0, i);
    sendFrame(200, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 0);
    checkOutput("sof_count", NW'(obsData.size()), NW'(6));
    checkOutput("sof_done", NW'(doneSeen), NW'(1));
    lst = '{200, 201, 202, 205, 206, 207, 210, 211, 212};
    checkObs("sof_first", 0);

    $display("[TB] reset in the middle of a frame");
    clearObs();
    for (int i = 0; i < 14; i++) applyStimulus(1'b1, i == 0, i);
    @(negedge clk);
    compareNow();
    checkOutput("pre_reset_count", NW'(obsData.size()), NW'(2));
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_sof   = 1'b0;
    modelReset();
    #1;
    checkOutput("midreset_oData", oData, '0);
    checkOutput("midreset_window_valid", {{(NW-1){1'b0}}, window_valid}, '0);
    @(negedge clk);
    compareNow();
    rst_n = 1'b1;
    clearObs();
    sendFrame(40, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 0);
    checkOutput("post_reset_count", NW'(obsData.size()), NW'(6));
    checkOutput("post_reset_done", NW'(doneSeen), NW'(1));
    lst = '{40, 41, 42, 45, 46, 47, 50, 51, 52};
    checkObs("post_reset_first", 0);

    $display("[TB] two frames back to back");
    clearObs();
    sendFrame(0, 1'b1, 1'b0);
    sendFrame(100, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 0);
    applyStimulus(1'b0, 1'b0, 0);
    checkOutput("b2b_count", NW'(obsData.size()), NW'(12));
    checkOutput("b2b_done", NW'(doneSeen), NW'(2));
    lst = '{100, 101, 102, 105, 106, 107, 110, 111, 112};
    checkObs("b2b_second_first", 6);
    lst = '{107, 108, 109, 112, 113, 114, 117, 118, 119};
    checkObs("b2b_second_last", 11);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
